// File: rtl/rom_arbiter.sv
// rom_arbiter: shares one sync ROM between a priority display port and a starvation-bounded decrypter port
// Ports: clk/rst (sync, active-low); disp_req/disp_addr -> disp_valid/disp_data;
// dec_req/dec_addr -> dec_gnt, dec_valid/dec_data; rom_addr/rom_dout to the ROM;
// disp_miss_cnt counts display requests lost to forced decrypter grants.
// MISS_RST is the reset value of disp_miss_cnt, left at 0 except to preset the counter.
module rom_arbiter #(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 8,
  parameter int MAX_WAIT = 64,
  parameter logic [15:0] MISS_RST = 16'd0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              disp_req,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic              disp_valid,
  output logic [DATA_W-1:0] disp_data,
  input  logic              dec_req,
  input  logic [ADDR_W-1:0] dec_addr,
  output logic              dec_gnt,
  output logic              dec_valid,
  output logic [DATA_W-1:0] dec_data,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_dout,
  output logic [15:0]       disp_miss_cnt
);
  typedef enum logic [1:0] {IDLE = 2'd0, DISP = 2'd1, DEC = 2'd2} slot_t;
  localparam logic [15:0] WMAX = 16'(MAX_WAIT - 1);
  slot_t w_slot, r_tag1, r_tag2;
  logic [15:0] r_wait;
  logic w_dec_ok, w_force;
  // a held request is never re-granted while its grant pulse is still high
  assign w_dec_ok = dec_req && !dec_gnt;
  assign w_force = w_dec_ok && (r_wait == WMAX);
  always_comb w_slot = w_force ? DEC : disp_req ? DISP : w_dec_ok ? DEC : IDLE;
  always_ff @(posedge clk) begin
    if (!rst) begin
      rom_addr <= '0;
      disp_data <= '0;
      dec_data <= '0;
      disp_valid <= 1'b0;
      dec_valid <= 1'b0;
      dec_gnt <= 1'b0;
      disp_miss_cnt <= MISS_RST;
      r_wait <= '0;
      r_tag1 <= IDLE;
      r_tag2 <= IDLE;
    end else begin
      if (w_slot == DISP) rom_addr <= disp_addr;
      else if (w_slot == DEC) rom_addr <= dec_addr;
      dec_gnt <= (w_slot == DEC);
      // tag stage 1 tracks the ROM address register, stage 2 the ROM output register
      r_tag1 <= w_slot;
      r_tag2 <= r_tag1;
      disp_valid <= (r_tag2 == DISP);
      dec_valid <= (r_tag2 == DEC);
      if (r_tag2 == DISP) disp_data <= rom_dout;
      if (r_tag2 == DEC) dec_data <= rom_dout;
      if (w_force && disp_req && disp_miss_cnt != 16'hFFFF) disp_miss_cnt <= disp_miss_cnt + 16'd1;
      r_wait <= (w_slot == DEC || !dec_req) ? 16'd0 : (!dec_gnt && r_wait != WMAX) ? r_wait + 16'd1 : r_wait;
    end
  end
endmodule

// File: tb/tb_rom_arbiter.sv
// tb_rom_arbiter: directed vector table plus pipeline, contention and saturation sequences
module tb_rom_arbiter;
  logic clk = 1'b0;
  logic rst;
  logic disp_req, dec_req, disp_valid, dec_valid, dec_gnt;
  logic [14:0] disp_addr, dec_addr, rom_addr;
  logic [7:0] disp_data, dec_data, rom_dout;
  logic [15:0] disp_miss_cnt;
  logic sat_on;
  logic s_dv, s_cv, s_g;
  logic [7:0] s_dd, s_cd, s_rom;
  logic [14:0] s_ra;
  logic [15:0] s_miss;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  rom_arbiter #(.ADDR_W(15), .DATA_W(8), .MAX_WAIT(4)) dut (
    .clk(clk), .rst(rst), .disp_req(disp_req), .disp_addr(disp_addr), .disp_valid(disp_valid),
    .disp_data(disp_data), .dec_req(dec_req), .dec_addr(dec_addr), .dec_gnt(dec_gnt),
    .dec_valid(dec_valid), .dec_data(dec_data), .rom_addr(rom_addr), .rom_dout(rom_dout),
    .disp_miss_cnt(disp_miss_cnt));
  rom_arbiter #(.ADDR_W(15), .DATA_W(8), .MAX_WAIT(2), .MISS_RST(16'hFFFD)) sat (
    .clk(clk), .rst(rst), .disp_req(sat_on), .disp_addr(15'h0011), .disp_valid(s_dv),
    .disp_data(s_dd), .dec_req(sat_on), .dec_addr(15'h0022), .dec_gnt(s_g),
    .dec_valid(s_cv), .dec_data(s_cd), .rom_addr(s_ra), .rom_dout(s_rom),
    .disp_miss_cnt(s_miss));
  function automatic logic [7:0] rom_f(input logic [14:0] a);
    return a[7:0] ^ 8'hB5;
  endfunction
  always @(posedge clk) begin
    rom_dout <= rom_f(rom_addr);
    s_rom <= rom_f(s_ra);
  end
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", n, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  typedef struct {
    logic dr; logic [14:0] da; logic cr; logic [14:0] ca;
    logic [14:0] ra; logic dv; logic [7:0] dd; logic g; logic cv; logic [7:0] cd; logic [15:0] m;
  } vec_t;
  vec_t tv [16];
  logic [7:0] q [$];
  initial begin
    int issued, last, dvs;
    logic prev_g;
    logic [15:0] m0;
    tv[0]  = '{1'b1, 15'h0010, 1'b0, 15'h0000, 15'h0010, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 16'd0};
    tv[1]  = '{1'b0, 15'h0000, 1'b0, 15'h0000, 15'h0010, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 16'd0};
    tv[2]  = '{1'b0, 15'h0000, 1'b0, 15'h0000, 15'h0010, 1'b1, 8'hA5, 1'b0, 1'b0, 8'h00, 16'd0};
    tv[3]  = '{1'b0, 15'h0000, 1'b1, 15'h1234, 15'h1234, 1'b0, 8'hA5, 1'b1, 1'b0, 8'h00, 16'd0};
    tv[4]  = '{1'b0, 15'h0000, 1'b1, 15'h1234, 15'h1234, 1'b0, 8'hA5, 1'b0, 1'b0, 8'h00, 16'd0};
    tv[5]  = '{1'b0, 15'h0000, 1'b0, 15'h0000, 15'h1234, 1'b0, 8'hA5, 1'b0, 1'b1, 8'h81, 16'd0};
    tv[6]  = '{1'b0, 15'h0000, 1'b0, 15'h0000, 15'h1234, 1'b0, 8'hA5, 1'b0, 1'b0, 8'h81, 16'd0};
    tv[7]  = '{1'b1, 15'h0020, 1'b1, 15'h0044, 15'h0020, 1'b0, 8'hA5, 1'b0, 1'b0, 8'h81, 16'd0};
    tv[8]  = '{1'b1, 15'h0020, 1'b1, 15'h0044, 15'h0020, 1'b0, 8'hA5, 1'b0, 1'b0, 8'h81, 16'd0};
    tv[9]  = '{1'b1, 15'h0020, 1'b1, 15'h0044, 15'h0020, 1'b1, 8'h95, 1'b0, 1'b0, 8'h81, 16'd0};
    tv[10] = '{1'b1, 15'h0020, 1'b1, 15'h0044, 15'h0044, 1'b1, 8'h95, 1'b1, 1'b0, 8'h81, 16'd1};
    tv[11] = '{1'b1, 15'h0020, 1'b0, 15'h0000, 15'h0020, 1'b1, 8'h95, 1'b0, 1'b0, 8'h81, 16'd1};
    tv[12] = '{1'b1, 15'h0020, 1'b0, 15'h0000, 15'h0020, 1'b0, 8'h95, 1'b0, 1'b1, 8'hF1, 16'd1};
    tv[13] = '{1'b0, 15'h0000, 1'b0, 15'h0000, 15'h0020, 1'b1, 8'h95, 1'b0, 1'b0, 8'hF1, 16'd1};
    tv[14] = '{1'b0, 15'h0000, 1'b0, 15'h0000, 15'h0020, 1'b1, 8'h95, 1'b0, 1'b0, 8'hF1, 16'd1};
    tv[15] = '{1'b0, 15'h0000, 1'b0, 15'h0000, 15'h0020, 1'b0, 8'h95, 1'b0, 1'b0, 8'hF1, 16'd1};
    rst = 1'b0; sat_on = 1'b0;
    disp_req = 1'b1; disp_addr = 15'h0077; dec_req = 1'b1; dec_addr = 15'h0033;
    tick(); tick();
    chk("rst_rom_addr", rom_addr, 0);
    chk("rst_disp_valid", disp_valid, 0);
    chk("rst_dec_gnt", dec_gnt, 0);
    chk("rst_dec_valid", dec_valid, 0);
    chk("rst_disp_data", disp_data, 0);
    chk("rst_dec_data", dec_data, 0);
    chk("rst_miss", disp_miss_cnt, 0);
    chk("rst_sat_miss", s_miss, 16'hFFFD);
    rst = 1'b1;
    for (int i = 0; i < 16; i++) begin
      disp_req = tv[i].dr; disp_addr = tv[i].da; dec_req = tv[i].cr; dec_addr = tv[i].ca;
      tick();
      chk($sformatf("v%0d_rom_addr", i), rom_addr, tv[i].ra);
      chk($sformatf("v%0d_disp_valid", i), disp_valid, tv[i].dv);
      chk($sformatf("v%0d_disp_data", i), disp_data, tv[i].dd);
      chk($sformatf("v%0d_dec_gnt", i), dec_gnt, tv[i].g);
      chk($sformatf("v%0d_dec_valid", i), dec_valid, tv[i].cv);
      chk($sformatf("v%0d_dec_data", i), dec_data, tv[i].cd);
      chk($sformatf("v%0d_miss", i), disp_miss_cnt, tv[i].m);
    end
    disp_req = 1'b1; disp_addr = 15'h0055; dec_req = 1'b0;
    tick();
    rst = 1'b0; disp_req = 1'b0;
    tick();
    chk("mid_rst_rom_addr", rom_addr, 0);
    chk("mid_rst_disp_data", disp_data, 0);
    chk("mid_rst_dec_data", dec_data, 0);
    chk("mid_rst_miss", disp_miss_cnt, 0);
    chk("mid_rst_gnt", dec_gnt, 0);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("mid_rst_dv%0d", i), disp_valid, 0);
      chk($sformatf("mid_rst_dd%0d", i), disp_data, 0);
      chk($sformatf("mid_rst_cv%0d", i), dec_valid, 0);
    end
    issued = 0; last = -1; dvs = 0; prev_g = 1'b0; m0 = disp_miss_cnt;
    dec_addr = 15'h4080;
    for (int c = 0; c < 72; c++) begin
      disp_req = (c < 64) && ((c / 8) % 2 == 0);
      disp_addr = 15'h0100 + 15'(issued);
      dec_req = (c < 64);
      tick();
      if (disp_req) issued++;
      chk("no_double_gnt", prev_g & dec_gnt, 0);
      prev_g = dec_gnt;
      if (dec_gnt) begin
        q.push_back(rom_f(dec_addr));
        dec_addr = dec_addr + 15'd1;
      end
      if (dec_valid) begin
        if (q.size() == 0) chk("dec_unexpected", dec_data, 8'hXX);
        else chk("dec_route", dec_data, q.pop_front());
      end
      if (disp_valid) begin
        int idx;
        idx = int'(disp_data ^ 8'hB5);
        dvs++;
        chk("disp_route", (idx > last && idx < issued) ? 1 : 0, 1);
        last = idx;
      end
    end
    chk("burst_dec_drained", q.size(), 0);
    chk("burst_disp_accounted", dvs + int'(disp_miss_cnt - m0), issued);
    chk("burst_had_misses", (disp_miss_cnt != m0) ? 1 : 0, 1);
    disp_req = 1'b0; dec_req = 1'b0;
    sat_on = 1'b1;
    for (int i = 0; i < 30; i++) tick();
    chk("sat_reach", s_miss, 16'hFFFF);
    for (int i = 0; i < 15; i++) tick();
    chk("sat_hold", s_miss, 16'hFFFF);
    sat_on = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/rom_arbiter.md
ROM_ARBITER -- requirements
Module: rom_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 15, ROM address width.
REQ-002 SHALL have parameter DATA_W, default 8, ROM data width.
REQ-003 SHALL have parameter MAX_WAIT, default 64, max cycles the decrypter waits before a forced grant (range 2..65535).
REQ-004 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port disp_req  input  1  display read request, high-priority requester.
REQ-007 SHALL have port disp_addr  input  ADDR_W  display read address.
REQ-008 SHALL have port disp_valid  output  1  disp_data updated this cycle.
REQ-009 SHALL have port disp_data  output  DATA_W  display read data, held between updates.
REQ-010 SHALL have port dec_req  input  1  decrypter read request, held with stable dec_addr until dec_gnt.
REQ-011 SHALL have port dec_addr  input  ADDR_W  decrypter read address.
REQ-012 SHALL have port dec_gnt  output  1  one-cycle pulse: dec_addr accepted.
REQ-013 SHALL have port dec_valid  output  1  dec_data updated this cycle.
REQ-014 SHALL have port dec_data  output  DATA_W  decrypter read data, held between updates.
REQ-015 SHALL have port rom_addr  output  ADDR_W  registered address to single-port sync ROM (1-cycle read latency).
REQ-016 SHALL have port rom_dout  input  DATA_W  ROM read data.
REQ-017 SHALL have port disp_miss_cnt  output  16  count of display requests dropped by forced grants, saturating.

Function
REQ-018 SHALL arbitrate once per cycle at edge t into three slot types: DISP, DEC, IDLE.
REQ-019 SHALL pick DEC if dec_req=1, dec_gnt=0 and wait_cnt=MAX_WAIT-1 (forced); else DISP if disp_req=1; else DEC if dec_req=1 and dec_gnt=0; else IDLE.
REQ-020 SHALL never grant DEC while dec_gnt is high (no double grant of one held request).
REQ-021 SHALL register rom_addr from the winner's address at edge t; IDLE holds rom_addr.
REQ-022 SHALL drive dec_gnt=1 for exactly the cycle after a DEC slot.
REQ-023 SHALL carry a 2-bit owner tag through two pipeline stages aligned to ROM latency.
REQ-024 SHALL, for a slot chosen at edge t, capture rom_dout into the owner's data register at edge t+2 and assert that owner's valid for the following cycle only.
REQ-025 SHALL sustain one read per cycle; back-to-back DISP slots yield consecutive disp_valid cycles.
REQ-026 SHALL keep wait_cnt: +1 each cycle dec_req=1, dec_gnt=0 and slot not DEC; clear on DEC slot or dec_req=0; never exceed MAX_WAIT-1.
REQ-027 SHALL, on a forced DEC slot with disp_req=1, produce no disp_valid for that slot, hold disp_data, and increment disp_miss_cnt (saturate at 65535).
REQ-028 SHALL treat requests arriving mid-pipeline independently; in-flight reads always complete to their tagged owner.

Reset
REQ-029 SHALL, when rst=0 at an edge: rom_addr=0, disp_data=0, dec_data=0, disp_valid=0, dec_valid=0, dec_gnt=0, disp_miss_cnt=0, wait_cnt=0, owner tags=IDLE.
REQ-030 SHALL discard in-flight reads on reset; no valid asserts from pre-reset slots.
REQ-031 SHALL ignore all requests while rst=0; first arbitration at first edge with rst=1.

Verification
REQ-032 SHALL cover: disp_req=1 addr 0x0010 at edge 0, ROM[0x0010]=0xA5 -> rom_addr=0x0010 after edge 0, disp_valid=1 and disp_data=0xA5 after edge 2.
REQ-033 SHALL cover: disp_req=0, dec_req=1 addr 0x1234 -> dec_gnt pulse one cycle, dec_valid with ROM[0x1234] two cycles after grant slot, no second grant for same request.
REQ-034 SHALL cover: MAX_WAIT=4, disp_req and dec_req held high -> DEC forced on 4th arbitration, one disp_valid gap, disp_miss_cnt=1, wait_cnt cleared.
REQ-035 SHALL cover: disp_miss_cnt preset path to 65535 via long contention -> stays 65535.
REQ-036 SHALL cover: rst=0 one cycle after a DISP slot -> no disp_valid appears, all outputs 0.
REQ-037 SHALL cover: alternating disp_req bursts of 8 with dec_req high -> every disp/dec datum matches its tagged address, no misrouting.
